// File: rtl/add_arbiter.sv
// add_arbiter: two-requester front end for one shared pipelined adder.
//
// Ports
//   clock, reset           single clock; synchronous active-high reset
//   reqN_valid/ready       operation handshake (N = 0, 1); ready is
//                          combinational from eligibility
//   reqN_a/b/cin           operands of the offered operation
//   rspN_valid/ready       result handshake; valid = result FIFO N non-empty
//   rspN_sum/cout          head of result FIFO N
//   add_a/b/cin            operands driven to the external adder (zero when idle)
//   add_sum/cout           adder result, LATENCY edges after issue
//   busy                   any tag in flight or any result FIFO non-empty
//
// Configuration macro
//   ADD_ARBITER_FIXED_PRIO_EN  defined: requester 0 always wins contention;
//                              undefined: round-robin.
module add_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [1:0]         req_valid;
    logic [1:0]         rsp_ready;
    logic [1:0]         elig;
    logic [1:0]         grant;
    logic [1:0]         wr_en;
    logic [1:0]         pop;

    logic [CNT_W-1:0]   credit_q [2];
    logic [CNT_W-1:0]   credit_d [2];
    logic [CNT_W-1:0]   count_q  [2];
    logic [CNT_W-1:0]   count_d  [2];
    logic [PTR_W-1:0]   wr_ptr_q [2];
    logic [PTR_W-1:0]   wr_ptr_d [2];
    logic [PTR_W-1:0]   rd_ptr_q [2];
    logic [PTR_W-1:0]   rd_ptr_d [2];
    // Entry layout: {cout, sum}
    logic [WIDTH:0]     mem_q    [2][DEPTH];
    logic [WIDTH:0]     mem_d    [2][DEPTH];

    logic [LATENCY-1:0] tag_v_q;
    logic [LATENCY-1:0] tag_v_d;
    logic [LATENCY-1:0] tag_id_q;
    logic [LATENCY-1:0] tag_id_d;

`ifndef ADD_ARBITER_FIXED_PRIO_EN
    logic               last_q;
    logic               last_d;
`endif

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin : arbitrate
        elig[0] = req_valid[0] && (credit_q[0] < CNT_MAX);
        elig[1] = req_valid[1] && (credit_q[1] < CNT_MAX);
        grant   = '0;
`ifdef ADD_ARBITER_FIXED_PRIO_EN
        if (elig[0])      grant = 2'b01;
        else if (elig[1]) grant = 2'b10;
`else
        // last_q holds the id of the most recent grant; the other one wins a tie
        if (elig == 2'b11) grant = last_q ? 2'b01 : 2'b10;
        else               grant = elig;
        last_d = (|grant) ? grant[1] : last_q;
`endif
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign add_a   = grant[0] ? req0_a   : (grant[1] ? req1_a   : '0);
    assign add_b   = grant[0] ? req0_b   : (grant[1] ? req1_b   : '0);
    assign add_cin = grant[0] ? req0_cin : (grant[1] ? req1_cin : 1'b0);

    // Tag pipeline mirrors the adder latency so the final stage lines up with add_sum
    always_comb begin : tag_shift
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = |grant;
        tag_id_d[0] = grant[1];
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_comb begin : result_fifos
        wr_en    = '0;
        pop      = '0;
        mem_d    = mem_q;
        credit_d = credit_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int unsigned n = 0; n < 2; n++) begin
            wr_en[n] = tag_v_q[LATENCY-1] && (tag_id_q[LATENCY-1] == 1'(n));
            pop[n]   = (count_q[n] != '0) && rsp_ready[n];
            if (wr_en[n]) begin
                mem_d[n][wr_ptr_q[n]] = {add_cout, add_sum};
                wr_ptr_d[n] = (wr_ptr_q[n] == PTR_LAST) ? '0 : wr_ptr_q[n] + 1'b1;
            end
            if (pop[n]) begin
                rd_ptr_d[n] = (rd_ptr_q[n] == PTR_LAST) ? '0 : rd_ptr_q[n] + 1'b1;
            end
            if (wr_en[n] && !pop[n])      count_d[n] = count_q[n] + 1'b1;
            else if (!wr_en[n] && pop[n]) count_d[n] = count_q[n] - 1'b1;
            // Credit covers tags in flight plus queued results, so FIFO N cannot overflow
            if (grant[n] && !pop[n])      credit_d[n] = credit_q[n] + 1'b1;
            else if (!grant[n] && pop[n]) credit_d[n] = credit_q[n] - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
`ifndef ADD_ARBITER_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
            for (int unsigned n = 0; n < 2; n++) begin
                credit_q[n] <= '0;
                count_q[n]  <= '0;
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                for (int unsigned d = 0; d < DEPTH; d++) mem_q[n][d] <= '0;
            end
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
`ifndef ADD_ARBITER_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
            credit_q <= credit_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign rsp0_valid = (count_q[0] != '0);
    assign rsp1_valid = (count_q[1] != '0);
    assign rsp0_sum   = mem_q[0][rd_ptr_q[0]][WIDTH-1:0];
    assign rsp0_cout  = mem_q[0][rd_ptr_q[0]][WIDTH];
    assign rsp1_sum   = mem_q[1][rd_ptr_q[1]][WIDTH-1:0];
    assign rsp1_cout  = mem_q[1][rd_ptr_q[1]][WIDTH];
    assign busy       = (|tag_v_q) || rsp0_valid || rsp1_valid;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: randomized and directed stimulus for add_arbiter, checked
// cycle by cycle against a transaction-level reference model (credits,
// expected-result queues, due times). Build with +define+ADD_ARBITER_FIXED_PRIO_EN
// to check the fixed-priority policy instead of round-robin.
module tb_add_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_cin, req1_cin;
    logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_sum, rsp1_sum;
    logic             rsp0_cout, rsp1_cout;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout, busy;

    always #5 clock = ~clock;

    add_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum),
        .rsp0_cout(rsp0_cout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum),
        .rsp1_cout(rsp1_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
    );

    // External pipelined adder: result visible LATENCY edges after the operands
    logic [WIDTH:0] adder_pipe [LATENCY];
    always @(posedge clock) begin
        adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int i = 1; i < LATENCY; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign add_sum  = adder_pipe[LATENCY-1][WIDTH-1:0];
    assign add_cout = adder_pipe[LATENCY-1][WIDTH];

    // Reference model state
    typedef struct {
        int             due;
        int             id;
        logic [WIDTH:0] val;
    } op_t;

    op_t            inflight[$];
    logic [WIDTH:0] exp_fifo0[$];
    logic [WIDTH:0] exp_fifo1[$];
    int             credit[2];
    int             last_grant;
    int             cyc;
    int             seen_grants0;
    int             num_checks;
    int             num_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        inflight.delete();
        exp_fifo0.delete();
        exp_fifo1.delete();
        credit[0]  = 0;
        credit[1]  = 0;
        last_grant = 1;
    endtask

    // Called just after a falling edge with inputs already driven; checks the
    // cycle, advances the model across the rising edge, returns at the next falling edge.
    task automatic step();
        int             g;
        bit             e0, e1;
        logic [WIDTH:0] r;
        logic [WIDTH-1:0] ea, eb;
        logic           ec;
        #1;
        if (reset) begin
            @(negedge clock);
            cyc++;
            model_clear();
            return;
        end
        while (inflight.size() > 0 && inflight[0].due <= cyc) begin
            if (inflight[0].id == 0) exp_fifo0.push_back(inflight[0].val);
            else                     exp_fifo1.push_back(inflight[0].val);
            inflight.delete(0);
        end
        e0 = req0_valid && (credit[0] < int'(DEPTH));
        e1 = req1_valid && (credit[1] < int'(DEPTH));
        g  = -1;
`ifdef ADD_ARBITER_FIXED_PRIO_EN
        if (e0)      g = 0;
        else if (e1) g = 1;
`else
        if (e0 && e1) g = (last_grant == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
`endif
        ea = (g == 0) ? req0_a   : (g == 1) ? req1_a   : '0;
        eb = (g == 0) ? req0_b   : (g == 1) ? req1_b   : '0;
        ec = (g == 0) ? req0_cin : (g == 1) ? req1_cin : 1'b0;
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        check("add_a", 64'(add_a), 64'(ea));
        check("add_b", 64'(add_b), 64'(eb));
        check("add_cin", 64'(add_cin), 64'(ec));
        check("rsp0_valid", 64'(rsp0_valid), 64'(exp_fifo0.size() > 0));
        check("rsp1_valid", 64'(rsp1_valid), 64'(exp_fifo1.size() > 0));
        if (exp_fifo0.size() > 0) check("rsp0_data", 64'({rsp0_cout, rsp0_sum}), 64'(exp_fifo0[0]));
        if (exp_fifo1.size() > 0) check("rsp1_data", 64'({rsp1_cout, rsp1_sum}), 64'(exp_fifo1[0]));
        check("busy", 64'(busy),
              64'(inflight.size() > 0 || exp_fifo0.size() > 0 || exp_fifo1.size() > 0));
        if (req0_ready) seen_grants0++;
        if (g == 0) begin
            r = {1'b0, req0_a} + {1'b0, req0_b} + (WIDTH+1)'(req0_cin);
            inflight.push_back('{cyc + int'(LATENCY) + 1, 0, r});
            credit[0]++;
            last_grant = 0;
        end else if (g == 1) begin
            r = {1'b0, req1_a} + {1'b0, req1_b} + (WIDTH+1)'(req1_cin);
            inflight.push_back('{cyc + int'(LATENCY) + 1, 1, r});
            credit[1]++;
            last_grant = 1;
        end
        if (exp_fifo0.size() > 0 && rsp0_ready) begin
            exp_fifo0.delete(0);
            credit[0]--;
        end
        if (exp_fifo1.size() > 0 && rsp1_ready) begin
            exp_fifo1.delete(0);
            credit[1]--;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_ops();
        req0_a = rand_operand(); req0_b = rand_operand(); req0_cin = 1'($urandom);
        req1_a = rand_operand(); req1_b = rand_operand(); req1_cin = 1'($urandom);
    endtask

    initial begin
        num_checks   = 0;
        num_errors   = 0;
        cyc          = 0;
        seen_grants0 = 0;
        model_clear();
        idle_inputs();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        reset      = 1'b1;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        check("reset_rsp0_sum", 64'(rsp0_sum), 64'd0);
        check("reset_rsp0_cout", 64'(rsp0_cout), 64'd0);
        check("reset_rsp1_sum", 64'(rsp1_sum), 64'd0);
        check("reset_rsp1_cout", 64'(rsp1_cout), 64'd0);
        repeat (2) step();

        // Single op on requester 0: 5 + 7 + 0
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_cin = 1'b0;
        step();
        idle_inputs();
        repeat (8) step();

        // Carry out on requester 1
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0; req1_cin = 1'b1;
        step();
        idle_inputs();
        repeat (8) step();

        // Contention with both consumers always ready
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            randomize_ops();
            step();
        end
        idle_inputs();
        repeat (8) step();

        // Backpressure on requester 0: credit caps issue at DEPTH
        rsp0_ready   = 1'b0;
        seen_grants0 = 0;
        req0_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            randomize_ops();
            step();
        end
        check("bp_grant_count", 64'(seen_grants0), 64'(DEPTH));
        rsp0_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            randomize_ops();
            step();
        end
        idle_inputs();
        repeat (8) step();

        // Randomized traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            randomize_ops();
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        idle_inputs();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (12) step();

        // Reset while three ops are in flight: first op at T, reset at T+2
        req0_valid = 1'b1;
        randomize_ops();
        step();
        randomize_ops();
        step();
        randomize_ops();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        check("busy_after_reset", 64'(busy), 64'd0);
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
